// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt controller for the pipelined RISC-V core.
// Latches NSRC level trap requests, masks them with mie, and redirects the
// highest-priority one (index 0 first) into a handler through a
// FLUSH_CYCLES-long PC redirect / pipeline flush. A later flush of the same
// length returns to mepc once the handler sets mipd.
//
// Build option: define TRAP_CTRL_VECTORED_EN for vectored entry
// (mtvec + sel*VEC_STRIDE). When it is undefined, every source enters at mtvec.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   irq_req[NSRC]             level trap requests
//   epc_in, tval_in           values captured into mepc / mtval on entry
//   csr_wen/wadd/din          CSR write port
//   csr_radd / csr_dout       combinational CSR read port (0 when unmapped)
//   pc_dout, pc_wen, npc_sel  PC redirect (OR-ed with the hazard unit)
//   if_id_clear, id_ex_clear  pipeline flush
//   in_trap                   high from entry until exit completes
//   trap_ack[NSRC]            one-hot pulse on the source being taken
module trap_ctrl #(
  parameter int unsigned NSRC         = 8,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] VEC_BASE     = 32'hF000,
  parameter int unsigned VEC_STRIDE   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_req,
  input  logic [31:0]     epc_in,
  input  logic [31:0]     tval_in,
  input  logic            csr_wen,
  input  logic [11:0]     csr_wadd,
  input  logic [31:0]     csr_din,
  input  logic [11:0]     csr_radd,
  output logic [31:0]     csr_dout,
  output logic [31:0]     pc_dout,
  output logic            pc_wen,
  output logic            npc_sel,
  output logic            if_id_clear,
  output logic            id_ex_clear,
  output logic            in_trap,
  output logic [NSRC-1:0] trap_ack
);

  localparam logic [3:0]  CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [11:0] A_MTVEC  = 12'h305;
  localparam logic [11:0] A_MIE    = 12'h304;
  localparam logic [11:0] A_MIP    = 12'h344;
  localparam logic [11:0] A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_MTVAL  = 12'h343;
  localparam logic [11:0] A_MIPD   = 12'h100;

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_HANDLER, S_EXIT} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic [NSRC-1:0] pending, mie, eff, take;
  logic [4:0]      sel;
  logic            found;
  logic [31:0]     mtvec, mcause, mepc, mtval, vector;
  logic            mipd;
  logic            capture, mipd_wr1, start_exit;

  // Priority select: lowest enabled index wins.
  always_comb begin
    eff   = (pending | irq_req) & mie;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eff[i] && !found) begin
        sel   = 5'(i);
        found = 1'b1;
      end
    end
  end

  assign capture    = (state == S_IDLE) && found && !rst;
  assign take       = capture ? (NSRC'(1) << sel) : '0;
  assign trap_ack   = take;
  assign mipd_wr1   = csr_wen && (csr_wadd == A_MIPD) && csr_din[0];
  assign start_exit = (state == S_HANDLER) && (mipd || mipd_wr1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (found)        state_nx = S_ENTER;
      S_ENTER:   if (cnt == '0)    state_nx = S_HANDLER;
      S_HANDLER: if (start_exit)   state_nx = S_EXIT;
      S_EXIT:    if (cnt == '0)    state_nx = S_IDLE;
      default:                     state_nx = S_IDLE;
    endcase
  end

  // Flush counter, pending latch and CSRs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= '0;
      mtvec   <= VEC_BASE;
      mie     <= '1;
      mcause  <= '0;
      mepc    <= '0;
      mtval   <= '0;
      mipd    <= 1'b0;
    end else begin
      if (capture || start_exit)
        cnt <= CNT_LOAD;
      else if ((state == S_ENTER || state == S_EXIT) && cnt != '0)
        cnt <= cnt - 4'd1;

      // A request in the same cycle as its own take keeps the bit set.
      pending <= (pending & ~take) | irq_req;

      if (csr_wen) begin
        unique case (csr_wadd)
          A_MTVEC:  mtvec  <= csr_din;
          A_MIE:    mie    <= csr_din[NSRC-1:0];
          A_MCAUSE: mcause <= csr_din;
          A_MEPC:   mepc   <= csr_din;
          A_MTVAL:  mtval  <= csr_din;
          A_MIPD:   mipd   <= csr_din[0];
          default: ;
        endcase
      end

      // Later assignment overrides a same-cycle software write.
      if (capture) begin
        mcause <= 32'(sel) + 32'd1;
        mepc   <= epc_in;
        mtval  <= tval_in;
        mipd   <= 1'b0;
      end
    end
  end

`ifdef TRAP_CTRL_VECTORED_EN
  logic [4:0] trap_sel;

  always_ff @(posedge clk) begin
    if (rst)          trap_sel <= '0;
    else if (capture) trap_sel <= sel;
  end

  assign vector = mtvec + 32'(trap_sel) * VEC_STRIDE;
`else
  assign vector = mtvec;
`endif

  // Moore outputs
  always_comb begin
    pc_dout     = '0;
    pc_wen      = 1'b0;
    npc_sel     = 1'b0;
    if_id_clear = 1'b0;
    id_ex_clear = 1'b0;
    in_trap     = (state != S_IDLE);
    if (state == S_ENTER || state == S_EXIT) begin
      pc_dout     = (state == S_ENTER) ? vector : mepc;
      pc_wen      = 1'b1;
      npc_sel     = 1'b1;
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
    end
  end

  // CSR read
  always_comb begin
    csr_dout = '0;
    unique case (csr_radd)
      A_MTVEC:  csr_dout = mtvec;
      A_MIE:    csr_dout = 32'(mie);
      A_MIP:    csr_dout = 32'(pending);
      A_MCAUSE: csr_dout = mcause;
      A_MEPC:   csr_dout = mepc;
      A_MTVAL:  csr_dout = mtval;
      A_MIPD:   csr_dout = {31'b0, mipd};
      default:  csr_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl (default parameters).
module tb_trap_ctrl;

`ifdef TRAP_CTRL_VECTORED_EN
  localparam int unsigned STRIDE_EFF = 8;
`else
  localparam int unsigned STRIDE_EFF = 0;
`endif
  localparam int FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_req;
  logic [31:0] epc_in, tval_in, csr_din, csr_dout, pc_dout;
  logic        csr_wen;
  logic [11:0] csr_wadd, csr_radd;
  logic        pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap;
  logic [7:0]  trap_ack;

  int n_cmp = 0;
  int n_fail = 0;

  trap_ctrl #(.NSRC(8), .FLUSH_CYCLES(3), .VEC_BASE(32'hF000), .VEC_STRIDE(8)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .epc_in(epc_in), .tval_in(tval_in),
    .csr_wen(csr_wen), .csr_wadd(csr_wadd), .csr_din(csr_din), .csr_radd(csr_radd),
    .csr_dout(csr_dout), .pc_dout(pc_dout), .pc_wen(pc_wen), .npc_sel(npc_sel),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .in_trap(in_trap),
    .trap_ack(trap_ack)
  );

  always #20 clk = ~clk;

  function automatic logic [31:0] exp_vec(input int s);
    return 32'hF000 + 32'(s) * STRIDE_EFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_radd = a;
    #1;
    d = csr_dout;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_wadd = a; csr_din = d;
    tick();
    csr_wen = 1'b0; csr_wadd = '0; csr_din = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; irq_req = '0; epc_in = '0; tval_in = '0;
    csr_wen = 1'b0; csr_wadd = '0; csr_din = '0; csr_radd = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_dut();
    n_cmp++; if ({pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap}); end
    n_cmp++; if (pc_dout !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_dout); end
    n_cmp++; if (trap_ack !== 8'h0) begin n_fail++; $display("FAIL reset_ack got=%h exp=0", trap_ack); end
    rd(12'h305, d); n_cmp++; if (d !== 32'hF000) begin n_fail++; $display("FAIL reset_mtvec got=%h exp=f000", d); end
    rd(12'h304, d); n_cmp++; if (d !== 32'hFF) begin n_fail++; $display("FAIL reset_mie got=%h exp=ff", d); end
    rd(12'h344, d); n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mip got=%h exp=0", d); end
    rd(12'h342, d); n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got=%h exp=0", d); end
  endtask

  task automatic test_vectored_entry();
    logic [31:0] d;
    reset_dut();
    irq_req = 8'b0000_0100; epc_in = 32'h40; tval_in = 32'h7; #1;
    n_cmp++; if (trap_ack !== 8'h04) begin n_fail++; $display("FAIL entry_ack got=%h exp=04", trap_ack); end
    tick();
    irq_req = '0; epc_in = '0; tval_in = '0; #1;
    for (int c = 0; c < FLUSH; c++) begin
      n_cmp++; if ({pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap} !== 5'b11111) begin
        n_fail++; $display("FAIL entry_flags[%0d] got=%b exp=11111", c, {pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap}); end
      n_cmp++; if (pc_dout !== exp_vec(2)) begin n_fail++; $display("FAIL entry_pc[%0d] got=%h exp=%h", c, pc_dout, exp_vec(2)); end
      n_cmp++; if (trap_ack !== 8'h0) begin n_fail++; $display("FAIL entry_ack_low[%0d] got=%h exp=0", c, trap_ack); end
      tick();
    end
    n_cmp++; if ({pc_wen, in_trap} !== 2'b01) begin n_fail++; $display("FAIL handler_flags got=%b exp=01", {pc_wen, in_trap}); end
    rd(12'h342, d); n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL entry_mcause got=%h exp=3", d); end
    rd(12'h341, d); n_cmp++; if (d !== 32'h40) begin n_fail++; $display("FAIL entry_mepc got=%h exp=40", d); end
    rd(12'h343, d); n_cmp++; if (d !== 32'h7) begin n_fail++; $display("FAIL entry_mtval got=%h exp=7", d); end
    // request was high on its own take edge, so it is still pending
    rd(12'h344, d); n_cmp++; if (d !== 32'h04) begin n_fail++; $display("FAIL entry_mip got=%h exp=04", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    reset_dut();
    wr(12'h304, 32'h0);
    irq_req = 8'b1000_0010; #1;
    n_cmp++; if (trap_ack !== 8'h0) begin n_fail++; $display("FAIL prio_masked_ack got=%h exp=0", trap_ack); end
    tick();
    irq_req = '0;
    wr(12'h304, 32'hFF);
    epc_in = 32'h200; #1;
    n_cmp++; if (trap_ack !== 8'h02) begin n_fail++; $display("FAIL prio_ack got=%h exp=02", trap_ack); end
    tick();
    epc_in = '0; #1;
    n_cmp++; if (pc_dout !== exp_vec(1)) begin n_fail++; $display("FAIL prio_pc got=%h exp=%h", pc_dout, exp_vec(1)); end
    rd(12'h344, d); n_cmp++; if (d !== 32'h80) begin n_fail++; $display("FAIL prio_mip got=%h exp=80", d); end
    tick(); tick(); tick();
    n_cmp++; if ({pc_wen, in_trap} !== 2'b01) begin n_fail++; $display("FAIL prio_handler got=%b exp=01", {pc_wen, in_trap}); end
    wr(12'h100, 32'h1);
    for (int c = 0; c < FLUSH; c++) begin
      n_cmp++; if (pc_dout !== 32'h200 || pc_wen !== 1'b1) begin
        n_fail++; $display("FAIL prio_exit[%0d] got=%h/%b exp=200/1", c, pc_dout, pc_wen); end
      tick();
    end
    n_cmp++; if (trap_ack !== 8'h80) begin n_fail++; $display("FAIL prio_second_ack got=%h exp=80", trap_ack); end
    tick();
    n_cmp++; if (pc_dout !== exp_vec(7)) begin n_fail++; $display("FAIL prio_second_pc got=%h exp=%h", pc_dout, exp_vec(7)); end
    rd(12'h342, d); n_cmp++; if (d !== 32'd8) begin n_fail++; $display("FAIL prio_second_mcause got=%h exp=8", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    reset_dut();
    wr(12'h304, 32'hFB);
    irq_req = 8'h04; tick();
    irq_req = '0; #1;
    n_cmp++; if ({pc_wen, in_trap} !== 2'b00) begin n_fail++; $display("FAIL mask_noentry got=%b exp=00", {pc_wen, in_trap}); end
    rd(12'h344, d); n_cmp++; if (d !== 32'h04) begin n_fail++; $display("FAIL mask_mip got=%h exp=04", d); end
    wr(12'h304, 32'hFF);
    n_cmp++; if (trap_ack !== 8'h04 || in_trap !== 1'b0) begin
      n_fail++; $display("FAIL mask_unmask_ack got=%h/%b exp=04/0", trap_ack, in_trap); end
    tick();
    n_cmp++; if ({pc_wen, in_trap} !== 2'b11) begin n_fail++; $display("FAIL mask_entry got=%b exp=11", {pc_wen, in_trap}); end
  endtask

  task automatic test_exit_mepc();
    reset_dut();
    irq_req = 8'h01; epc_in = 32'h40; tick();
    irq_req = '0; epc_in = '0;
    tick(); tick(); tick();
    wr(12'h341, 32'h100);
    wr(12'h100, 32'h1);
    for (int c = 0; c < FLUSH; c++) begin
      n_cmp++; if ({pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap} !== 5'b11111 || pc_dout !== 32'h100) begin
        n_fail++; $display("FAIL exit_cycle[%0d] got=%h/%b exp=100/11111", c, pc_dout, {pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap}); end
      tick();
    end
    n_cmp++; if ({pc_wen, npc_sel, in_trap} !== 3'b000 || pc_dout !== 32'h0) begin
      n_fail++; $display("FAIL exit_idle got=%h/%b exp=0/000", pc_dout, {pc_wen, npc_sel, in_trap}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    reset_dut();
    wr(12'h305, 32'h1234);
    wr(12'h304, 32'h0F);
    irq_req = 8'h08; tick();
    irq_req = '0; tick();
    rst = 1'b1; irq_req = 8'h01; tick();
    n_cmp++; if ({pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap} !== 5'b0 || pc_dout !== 32'h0 || trap_ack !== 8'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got=%h/%b/%h exp=0/00000/0", pc_dout, {pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap}, trap_ack); end
    rd(12'h305, d); n_cmp++; if (d !== 32'hF000) begin n_fail++; $display("FAIL rstmid_mtvec got=%h exp=f000", d); end
    rd(12'h304, d); n_cmp++; if (d !== 32'hFF) begin n_fail++; $display("FAIL rstmid_mie got=%h exp=ff", d); end
    rd(12'h344, d); n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_mip got=%h exp=0", d); end
    irq_req = '0; rst = 1'b0;
  endtask

  task automatic test_source5();
    logic [31:0] d;
    reset_dut();
    irq_req = 8'h20; tick();
    irq_req = '0; #1;
    n_cmp++; if (pc_dout !== exp_vec(5)) begin n_fail++; $display("FAIL src5_pc got=%h exp=%h", pc_dout, exp_vec(5)); end
    rd(12'h342, d); n_cmp++; if (d !== 32'd6) begin n_fail++; $display("FAIL src5_mcause got=%h exp=6", d); end
  endtask

  // Reference model: a trap is a timeline of FLUSH redirect cycles, an
  // open-ended handler phase, and FLUSH return cycles.
  task automatic test_random();
    logic [7:0]  mp, mmie, e_eff, e_ack;
    logic [31:0] mtv, mca, mep, mtva, e_pc, e_rd;
    logic        mmipd, flushing, handler, trig;
    int          flush_left, msel, e_sel;
    bit          busy, exiting;
    reset_dut();
    mp = '0; mmie = 8'hFF; mtv = 32'hF000; mca = '0; mep = '0; mtva = '0; mmipd = 1'b0;
    flush_left = 0; msel = 0; busy = 0; exiting = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      irq_req = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0;
      epc_in = $urandom; tval_in = $urandom;
      csr_wen = 1'b0; csr_wadd = '0; csr_din = $urandom;
      case ($urandom_range(0, 15))
        0: begin csr_wen = 1'b1; csr_wadd = 12'h304; end
        1: begin csr_wen = 1'b1; csr_wadd = 12'h100; end
        2: begin csr_wen = 1'b1; csr_wadd = 12'h341; end
        3: begin csr_wen = 1'b1; csr_wadd = 12'h342; end
        4: begin csr_wen = 1'b1; csr_wadd = 12'h343; end
        5: begin csr_wen = 1'b1; csr_wadd = 12'h305; end
        6: begin csr_wen = 1'b1; csr_wadd = 12'h100; csr_din = 32'h1; end
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: csr_radd = 12'h305; 1: csr_radd = 12'h304; 2: csr_radd = 12'h344;
        3: csr_radd = 12'h342; 4: csr_radd = 12'h341; 5: csr_radd = 12'h343;
        6: csr_radd = 12'h100; default: csr_radd = 12'($urandom);
      endcase
      #1;
      e_eff = (mp | irq_req) & mmie;
      e_ack = '0; e_sel = 0;
      if (!busy && e_eff != 0) begin
        for (int i = 7; i >= 0; i--) if (e_eff[i]) e_sel = i;
        e_ack[e_sel] = 1'b1;
      end
      flushing = (flush_left > 0);
      e_pc = !flushing ? 32'h0 : (exiting ? mep : mtv + 32'(msel) * STRIDE_EFF);
      case (csr_radd)
        12'h305: e_rd = mtv;
        12'h304: e_rd = {24'h0, mmie};
        12'h344: e_rd = {24'h0, mp};
        12'h342: e_rd = mca;
        12'h341: e_rd = mep;
        12'h343: e_rd = mtva;
        12'h100: e_rd = {31'h0, mmipd};
        default: e_rd = 32'h0;
      endcase
      n_cmp++; if (pc_dout !== e_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc_dout, e_pc); end
      n_cmp++; if ({pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap} !== {flushing, flushing, flushing, flushing, busy}) begin
        n_fail++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {pc_wen, npc_sel, if_id_clear, id_ex_clear, in_trap}, {flushing, flushing, flushing, flushing, busy}); end
      n_cmp++; if (trap_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%h exp=%h", cyc, trap_ack, e_ack); end
      n_cmp++; if (csr_dout !== e_rd) begin n_fail++; $display("FAIL rnd_csr cyc=%0d addr=%h got=%h exp=%h", cyc, csr_radd, csr_dout, e_rd); end
      // advance the model across the coming edge
      handler = busy && !flushing;
      trig = mmipd || (csr_wen && csr_wadd == 12'h100 && csr_din[0]);
      if (flushing) begin
        flush_left--;
        if (flush_left == 0 && exiting) begin busy = 0; exiting = 0; end
      end else if (handler && trig) begin
        flush_left = FLUSH; exiting = 1;
      end
      if (csr_wen) begin
        case (csr_wadd)
          12'h305: mtv = csr_din;
          12'h304: mmie = csr_din[7:0];
          12'h342: mca = csr_din;
          12'h341: mep = csr_din;
          12'h343: mtva = csr_din;
          12'h100: mmipd = csr_din[0];
          default: ;
        endcase
      end
      if (e_ack != 0) begin
        busy = 1; flush_left = FLUSH; msel = e_sel;
        mca = 32'(e_sel + 1); mep = epc_in; mtva = tval_in; mmipd = 1'b0;
      end
      mp = (mp & ~e_ack) | irq_req;
      tick();
    end
    csr_wen = 1'b0; irq_req = '0;
  endtask

  initial begin
    test_reset();
    test_vectored_entry();
    test_priority();
    test_mask();
    test_exit_mepc();
    test_reset_mid();
    test_source5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
